// File: rtl/parallax_layer.sv
// One parallax skyline layer: LFSR-driven building heights, frame-rate horizontal
// scrolling in either direction, and a per-line vertical ramp of storeys.
module parallax_layer #(
    parameter int                LFSR_W     = 9,
    parameter int                TAP        = 4,
    parameter logic [LFSR_W-1:0] SEED       = '1,
    parameter int                HGT_BITS   = 4,
    parameter int                COL_LOG2   = 3,
    parameter int                EDGE_PX    = 2,
    parameter int                START_LINE = 116,
    parameter int                ROW_H      = 16,
    parameter int                ROOF_LINES = 2,
    parameter int                MAX_LEVEL  = 16,
    parameter int                SPEED_DIV  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pix_en,
    input  logic                             line_strobe,
    input  logic                             frame_strobe,
    input  logic                             frame_clr,
    input  logic [9:0]                       ypos,
    input  logic                             scroll_en,
    input  logic                             scroll_dir,
    output logic                             hit,
    output logic                             edge_o,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
    output logic                             full
);

    localparam int LVL_W = $clog2(MAX_LEVEL + 1);
    localparam int ROW_W = (ROW_H > 1) ? $clog2(ROW_H) : 1;
    localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int CMP_W = ((HGT_BITS + 1) > LVL_W) ? (HGT_BITS + 1) : LVL_W;

    localparam logic [COL_LOG2-1:0] COL_LAST = '1;
    localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(ROW_H - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SPEED_DIV - 1);
    localparam logic [LVL_W-1:0]    LVL_MAX  = LVL_W'(MAX_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_fwd(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[TAP]};
    endfunction

    // Exact inverse of lfsr_fwd: the shifted-out bit is recovered from the feedback bit.
    function automatic logic [LFSR_W-1:0] lfsr_rev(input logic [LFSR_W-1:0] v);
        return {v[0] ^ v[TAP+1], v[LFSR_W-1:1]};
    endfunction

    logic [LFSR_W-1:0]   base_lfsr_q, base_lfsr_d;
    logic [LFSR_W-1:0]   line_lfsr_q, line_lfsr_d;
    logic [COL_LOG2-1:0] base_cnt_q,  base_cnt_d;
    logic [COL_LOG2-1:0] line_cnt_q,  line_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q,   div_cnt_d;
    state_t              state_q,     state_d;
    logic [LVL_W-1:0]    level_q,     level_d;
    logic [ROW_W-1:0]    row_cnt_q,   row_cnt_d;
    logic                vborder_q,   vborder_d;
    logic                hit_q,       hit_d;
    logic                edge_q,      edge_d;
    logic                full_q,      full_d;
    logic                row_step_s;
    logic [HGT_BITS-1:0] height_s;

    // Frame-rate scroll of the base (left-of-screen) column position.
    always_comb begin
        base_lfsr_d = base_lfsr_q;
        base_cnt_d  = base_cnt_q;
        div_cnt_d   = div_cnt_q;
        if (frame_strobe && scroll_en) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (!scroll_dir) begin
                    if (base_cnt_q == '0) begin
                        base_lfsr_d = lfsr_fwd(base_lfsr_q);
                    end else begin
                        base_lfsr_d = base_lfsr_q;
                    end
                    base_cnt_d = base_cnt_q + COL_LOG2'(1);
                end else begin
                    if (base_cnt_q == COL_LOG2'(1)) begin
                        base_lfsr_d = lfsr_rev(base_lfsr_q);
                    end else begin
                        base_lfsr_d = base_lfsr_q;
                    end
                    base_cnt_d = base_cnt_q - COL_LOG2'(1);
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Per-line restore from the base position, then walk across the visible pixels.
    always_comb begin
        line_lfsr_d = line_lfsr_q;
        line_cnt_d  = line_cnt_q;
        if (line_strobe) begin
            line_lfsr_d = base_lfsr_q;
            line_cnt_d  = base_cnt_q;
        end else if (pix_en) begin
            if (line_cnt_q == '0) begin
                line_lfsr_d = lfsr_fwd(line_lfsr_q);
            end else begin
                line_lfsr_d = line_lfsr_q;
            end
            line_cnt_d = line_cnt_q + COL_LOG2'(1);
        end else begin
            line_cnt_d = line_cnt_q;
        end
    end

    // Vertical ramp FSM: one row step per line once the start line has been seen.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        row_cnt_d  = row_cnt_q;
        vborder_d  = vborder_q;
        row_step_s = 1'b0;
        if (frame_clr) begin
            state_d   = ST_IDLE;
            level_d   = '0;
            row_cnt_d = ROW_LAST;
            vborder_d = 1'b0;
        end else if (line_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (ypos == 10'(START_LINE)) begin
                        state_d    = ST_RUN;
                        row_step_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN:  row_step_s = 1'b1;
                ST_FULL: row_step_s = 1'b1;
                default: state_d = ST_IDLE;
            endcase
            if (row_step_s) begin
                vborder_d = (row_cnt_q < ROW_W'(ROOF_LINES));
                if (row_cnt_q == '0) begin
                    row_cnt_d = ROW_LAST;
                    if (level_q != LVL_MAX) begin
                        level_d = level_q + LVL_W'(1);
                    end else begin
                        level_d = level_q;
                    end
                end else begin
                    row_cnt_d = row_cnt_q - ROW_W'(1);
                end
                if (level_d == LVL_MAX) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = state_d;
                end
            end else begin
                vborder_d = vborder_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Pixel classification against the current column height and storey count.
    always_comb begin
        height_s = line_lfsr_q[HGT_BITS-1:0];
        hit_d    = pix_en && (CMP_W'(height_s) < CMP_W'(level_q));
        edge_d   = hit_d && (vborder_q || (line_cnt_q < COL_LOG2'(EDGE_PX)));
        full_d   = (state_d == ST_FULL);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_lfsr_q <= SEED;
            line_lfsr_q <= SEED;
            base_cnt_q  <= COL_LAST;
            line_cnt_q  <= COL_LAST;
            div_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            level_q     <= '0;
            row_cnt_q   <= ROW_LAST;
            vborder_q   <= 1'b0;
            hit_q       <= 1'b0;
            edge_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            base_lfsr_q <= base_lfsr_d;
            line_lfsr_q <= line_lfsr_d;
            base_cnt_q  <= base_cnt_d;
            line_cnt_q  <= line_cnt_d;
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            level_q     <= level_d;
            row_cnt_q   <= row_cnt_d;
            vborder_q   <= vborder_d;
            hit_q       <= hit_d;
            edge_q      <= edge_d;
            full_q      <= full_d;
        end
    end

    assign hit    = hit_q;
    assign edge_o = edge_q;
    assign level  = level_q;
    assign full   = full_q;

endmodule

// File: tb/tb_parallax_layer.sv
// Randomised bench for parallax_layer against a position-based reference model:
// scrolling is tracked as an absolute column number, the ramp as a count of lines.
module tb_parallax_layer;

    logic       clk = 1'b0;
    logic       rst_n, pix_en, line_strobe, frame_strobe, frame_clr;
    logic       scroll_en, scroll_dir;
    logic [9:0] ypos;
    logic       hit, edge_o, full, hit3, edge3, full3;
    logic [4:0] level, level3;

    int checks = 0;
    int errors = 0;

    // Model state: absolute base column, line column, lines since ramp start.
    int m_c, m_c3, m_div3, m_col, m_n;
    bit m_run;

    always #5 clk = ~clk;

    parallax_layer dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .line_strobe(line_strobe),
        .frame_strobe(frame_strobe), .frame_clr(frame_clr), .ypos(ypos),
        .scroll_en(scroll_en), .scroll_dir(scroll_dir),
        .hit(hit), .edge_o(edge_o), .level(level), .full(full)
    );

    parallax_layer #(.SPEED_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .line_strobe(line_strobe),
        .frame_strobe(frame_strobe), .frame_clr(frame_clr), .ypos(ypos),
        .scroll_en(scroll_en), .scroll_dir(scroll_dir),
        .hit(hit3), .edge_o(edge3), .level(level3), .full(full3)
    );

    function automatic logic [8:0] lfsr_at(input int k);
        logic [8:0] v;
        v = 9'h1FF;
        for (int i = 0; i < k; i++) v = {v[7:0], v[8] ^ v[4]};
        return v;
    endfunction

    // Column c uses the LFSR value reached after floor((c-1)/8) steps from the seed.
    function automatic logic [8:0] lfsr_of_col(input int c);
        return lfsr_at((c - 1) / 8);
    endfunction

    function automatic int m_level(input int n);
        return (n / 16 > 16) ? 16 : n / 16;
    endfunction

    function automatic bit m_vb(input int n);
        return (n > 0) && (((n - 1) % 16) >= 14);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_c = 7; m_c3 = 7; m_div3 = 0; m_col = 7; m_n = 0; m_run = 0;
    endtask

    // One clock with the current inputs; model advanced, hit/edge checked afterwards.
    task automatic step();
        logic eh, ee;
        int   hgt;
        hgt = int'(lfsr_of_col(m_col) & 9'h00F);
        eh  = pix_en && (hgt < m_level(m_n));
        ee  = eh && (m_vb(m_n) || ((m_col % 8) < 2));
        if (line_strobe) m_col = m_c;
        else if (pix_en) m_col = m_col + 1;
        if (frame_clr) begin
            m_run = 0; m_n = 0;
        end else if (line_strobe) begin
            if (m_run) m_n = m_n + 1;
            else if (ypos == 10'd116) begin m_run = 1; m_n = 1; end
        end
        if (frame_strobe && scroll_en) begin
            m_c = scroll_dir ? m_c - 1 : m_c + 1;
            m_div3 = m_div3 + 1;
            if (m_div3 == 3) begin
                m_div3 = 0;
                m_c3 = scroll_dir ? m_c3 - 1 : m_c3 + 1;
            end
        end
        @(posedge clk); #1;
        check("hit", {31'd0, hit}, {31'd0, eh});
        check("edge", {31'd0, edge_o}, {31'd0, ee});
    endtask

    task automatic check_base();
        check("base_lfsr", {23'd0, dut.base_lfsr_q}, {23'd0, lfsr_of_col(m_c)});
        check("base_cnt", {29'd0, dut.base_cnt_q}, m_c % 8);
        check("base_lfsr_div3", {23'd0, dut3.base_lfsr_q}, {23'd0, lfsr_of_col(m_c3)});
        check("base_cnt_div3", {29'd0, dut3.base_cnt_q}, m_c3 % 8);
    endtask

    task automatic check_vert();
        check("level", {27'd0, level}, m_level(m_n));
        check("vborder", {31'd0, dut.vborder_q}, {31'd0, m_vb(m_n)});
        check("full", {31'd0, full}, {31'd0, m_n >= 256});
    endtask

    task automatic ramp(input int y0, input int y1);
        line_strobe = 1'b1;
        for (int y = y0; y <= y1; y++) begin
            ypos = 10'(y);
            step();
            check_vert();
        end
        line_strobe = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; line_strobe = 1'b0; frame_strobe = 1'b0;
        frame_clr = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0; ypos = 10'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_edge", {31'd0, edge_o}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_base_lfsr", {23'd0, dut.base_lfsr_q}, 32'h1FF);
        check("rst_base_cnt", {29'd0, dut.base_cnt_q}, 32'd7);
        rst_n = 1'b1;

        // Forward scroll: two frames, FSM held idle by frame_clr.
        frame_clr = 1'b1; scroll_en = 1'b1; scroll_dir = 1'b0;
        frame_strobe = 1'b1; line_strobe = 1'b1;
        step();
        check("fwd1_cnt", {29'd0, dut.base_cnt_q}, 32'd0);
        check("fwd1_lfsr", {23'd0, dut.base_lfsr_q}, 32'h1FF);
        step();
        check("fwd2_cnt", {29'd0, dut.base_cnt_q}, 32'd1);
        check("fwd2_lfsr", {23'd0, dut.base_lfsr_q}, 32'h1FE);

        // 20 forward then 20 reverse steps return to the starting position.
        for (int i = 0; i < 40; i++) begin
            scroll_dir = (i >= 20);
            step();
        end
        check("round_trip_lfsr", {23'd0, dut.base_lfsr_q}, 32'h1FE);
        check("round_trip_cnt", {29'd0, dut.base_cnt_q}, 32'd1);
        check_base();

        // Randomised scrolling with gaps and disabled frames.
        for (int i = 0; i < 80; i++) begin
            frame_strobe = ($urandom_range(0, 3) != 0);
            line_strobe  = frame_strobe;
            scroll_en    = ($urandom_range(0, 3) != 0);
            scroll_dir   = ($urandom_range(0, 2) == 0) && (m_c > 9) && (m_c3 > 9);
            step();
            check_base();
        end
        frame_strobe = 1'b0; line_strobe = 1'b0; scroll_dir = 1'b0;

        // Vertical ramp to FULL; lines before 116 must not start it.
        frame_clr = 1'b0;
        ramp(110, 380);

        // frame_clr in the middle of a run.
        frame_clr = 1'b1; step(); check_vert(); frame_clr = 1'b0;
        ramp(116, 160);
        frame_clr = 1'b1; step();
        check("clr_level", {27'd0, level}, 32'd0);
        check("clr_full", {31'd0, full}, 32'd0);
        frame_clr = 1'b0;

        // Ramp to level 6, then pixel runs with reloads, coincident frames and gaps.
        ramp(116, 211);
        check("level6", {27'd0, level}, 32'd6);
        ypos = 10'd300;
        for (int ln = 0; ln < 16; ln++) begin
            line_strobe  = 1'b1;
            pix_en       = ln[0];
            frame_strobe = (ln % 4 == 3);
            scroll_en    = 1'b1;
            scroll_dir   = 1'b0;
            step();
            line_strobe = 1'b0; frame_strobe = 1'b0;
            for (int p = 0; p < 40; p++) begin
                pix_en = ($urandom_range(0, 7) != 0);
                step();
            end
            pix_en = 1'b0;
            step();
            check_vert();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
